// File: rtl/mpsoc_uart_apb_arbiter.sv
// Round-robin arbiter sharing the UART APB slave port among REQUESTERS local masters.
// Optional ACCESS-phase watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module mpsoc_uart_apb_arbiter #(
  parameter int REQUESTERS     = 2,
  parameter int APB_ADDR_WIDTH = 10,
  parameter int APB_DATA_WIDTH = 8,
  parameter int TIMEOUT        = 255
) (
  input  logic                                 HCLK,
  input  logic                                 HRESETn,
  input  logic [REQUESTERS-1:0]                req_i,
  input  logic [REQUESTERS-1:0]                we_i,
  input  logic [REQUESTERS*APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [REQUESTERS*APB_DATA_WIDTH-1:0] wdata_i,
  output logic [REQUESTERS-1:0]                gnt_o,
  output logic [REQUESTERS-1:0]                done_o,
  output logic [APB_DATA_WIDTH-1:0]            rdata_o,
  output logic                                 err_o,
  output logic                                 PSEL,
  output logic                                 PENABLE,
  output logic                                 PWRITE,
  output logic [APB_ADDR_WIDTH-1:0]            PADDR,
  output logic [APB_DATA_WIDTH-1:0]            PWDATA,
  input  logic [APB_DATA_WIDTH-1:0]            PRDATA,
  input  logic                                 PREADY,
  input  logic                                 PSLVERR
);

  localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                    state_reg, state_next;
  logic [REQUESTERS-1:0]     last_reg, last_next;
  logic [REQUESTERS-1:0]     gnt_reg, gnt_next;
  logic [REQUESTERS-1:0]     done_reg, done_next;
  logic [APB_DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic                      err_reg, err_next;
  logic                      psel_reg, psel_next;
  logic                      penable_reg, penable_next;
  logic                      pwrite_reg, pwrite_next;
  logic [APB_ADDR_WIDTH-1:0] paddr_reg, paddr_next;
  logic [APB_DATA_WIDTH-1:0] pwdata_reg, pwdata_next;

  logic [APB_ADDR_WIDTH-1:0] addr_arr  [REQUESTERS];
  logic [APB_DATA_WIDTH-1:0] wdata_arr [REQUESTERS];

  generate
    for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_unpack
      assign addr_arr[gi]  = addr_i[gi*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
      assign wdata_arr[gi] = wdata_i[gi*APB_DATA_WIDTH +: APB_DATA_WIDTH];
    end
  endgenerate

  // Rotate requests so bit 0 corresponds to the requester just after 'last'.
  logic [IDX_W-1:0]        last_idx;
  logic [2*REQUESTERS-1:0] req_dbl;
  logic [REQUESTERS-1:0]   req_rot;
  int                      sel_pos;
  logic [IDX_W-1:0]        sel_idx;
  logic [REQUESTERS-1:0]   sel_onehot;

  always_comb begin
    last_idx = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (last_reg[i]) last_idx = IDX_W'(i);
    end
  end

  assign req_dbl = {req_i, req_i} >> (int'(last_idx) + 1);
  assign req_rot = req_dbl[REQUESTERS-1:0];

  always_comb begin
    sel_pos = 0;
    for (int i = REQUESTERS - 1; i >= 0; i--) begin
      if (req_rot[i]) sel_pos = int'(last_idx) + 1 + i;
    end
    if (sel_pos >= REQUESTERS) sel_pos = sel_pos - REQUESTERS;
    sel_idx             = IDX_W'(sel_pos);
    sel_onehot          = '0;
    sel_onehot[sel_idx] = 1'b1;
  end

  logic timeout_hit;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_BITS = $clog2(TIMEOUT + 1);
  localparam int TO_W    = (TO_BITS < 8) ? 8 : ((TO_BITS > 16) ? 16 : TO_BITS);

  logic [TO_W-1:0] to_cnt_reg;

  // Cleared while idle, so every transfer enters SETUP with a fresh count.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      to_cnt_reg <= '0;
    end else if (state_reg == IDLE) begin
      to_cnt_reg <= '0;
    end else if (state_reg == ACCESS && !PREADY) begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end

  assign timeout_hit = (state_reg == ACCESS) && !PREADY &&
                       (to_cnt_reg == TO_W'(TIMEOUT - 1));
`else
  // No watchdog in this build: ACCESS waits for PREADY indefinitely.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_reg   <= IDLE;
      last_reg    <= {1'b1, {(REQUESTERS-1){1'b0}}};
      gnt_reg     <= '0;
      done_reg    <= '0;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
      psel_reg    <= 1'b0;
      penable_reg <= 1'b0;
      pwrite_reg  <= 1'b0;
      paddr_reg   <= '0;
      pwdata_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      last_reg    <= last_next;
      gnt_reg     <= gnt_next;
      done_reg    <= done_next;
      rdata_reg   <= rdata_next;
      err_reg     <= err_next;
      psel_reg    <= psel_next;
      penable_reg <= penable_next;
      pwrite_reg  <= pwrite_next;
      paddr_reg   <= paddr_next;
      pwdata_reg  <= pwdata_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    last_next    = last_reg;
    gnt_next     = gnt_reg;
    done_next    = '0;
    rdata_next   = rdata_reg;
    err_next     = err_reg;
    psel_next    = psel_reg;
    penable_next = penable_reg;
    pwrite_next  = pwrite_reg;
    paddr_next   = paddr_reg;
    pwdata_next  = pwdata_reg;
    case (state_reg)
      IDLE: begin
        if (|req_i) begin
          gnt_next     = sel_onehot;
          pwrite_next  = we_i[sel_idx];
          paddr_next   = addr_arr[sel_idx];
          pwdata_next  = wdata_arr[sel_idx];
          psel_next    = 1'b1;
          penable_next = 1'b0;
          state_next   = SETUP;
        end else begin
          psel_next    = 1'b0;
          penable_next = 1'b0;
          pwrite_next  = 1'b0;
          paddr_next   = '0;
          pwdata_next  = '0;
        end
      end
      SETUP: begin
        penable_next = 1'b1;
        state_next   = ACCESS;
      end
      ACCESS: begin
        if (PREADY || timeout_hit) begin
          done_next    = gnt_reg;
          last_next    = gnt_reg;
          gnt_next     = '0;
          psel_next    = 1'b0;
          penable_next = 1'b0;
          pwrite_next  = 1'b0;
          paddr_next   = '0;
          pwdata_next  = '0;
          state_next   = IDLE;
          // A slave response always wins over a same-cycle watchdog expiry.
          if (PREADY) begin
            rdata_next = pwrite_reg ? '0 : PRDATA;
            err_next   = PSLVERR;
          end else begin
            rdata_next = '0;
            err_next   = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign gnt_o   = gnt_reg;
  assign done_o  = done_reg;
  assign rdata_o = rdata_reg;
  assign err_o   = err_reg;
  assign PSEL    = psel_reg;
  assign PENABLE = penable_reg;
  assign PWRITE  = pwrite_reg;
  assign PADDR   = paddr_reg;
  assign PWDATA  = pwdata_reg;

endmodule

// File: tb/tb_mpsoc_uart_apb_arbiter.sv
// Scoreboard bench for mpsoc_uart_apb_arbiter: stimulus pushes expected APB and completion
// records, independent monitors pop and compare them.
module tb_mpsoc_uart_apb_arbiter;

  localparam int R  = 2;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int TO = 16;

  logic            HCLK = 1'b0;
  logic            HRESETn = 1'b0;
  logic [R-1:0]    req_i = '0;
  logic [R-1:0]    we_i = '0;
  logic [R*AW-1:0] addr_i = '0;
  logic [R*DW-1:0] wdata_i = '0;
  logic [R-1:0]    gnt_o;
  logic [R-1:0]    done_o;
  logic [DW-1:0]   rdata_o;
  logic            err_o;
  logic            PSEL, PENABLE, PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA;
  logic [DW-1:0]   PRDATA = '0;
  logic            PREADY = 1'b0;
  logic            PSLVERR = 1'b0;

  mpsoc_uart_apb_arbiter #(
    .REQUESTERS(R), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [R-1:0]  gnt;
  } apb_exp_t;

  typedef struct packed {
    logic [R-1:0]  done;
    logic [DW-1:0] rdata;
    logic          err;
  } done_exp_t;

  apb_exp_t  apb_q[$];
  done_exp_t done_q[$];

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // APB slave: inserts slv_wait PREADY=0 cycles into each ACCESS phase.
  int unsigned slv_wait = 0;
  int unsigned wcnt = 0;
  logic [DW-1:0] slv_rdata = '0;
  logic          slv_err = 1'b0;

  always @(posedge HCLK) begin
    #1;
    if (PSEL && PENABLE) begin
      if (wcnt >= slv_wait) begin
        PREADY  = 1'b1;
        PRDATA  = slv_rdata;
        PSLVERR = slv_err;
      end else begin
        PREADY  = 1'b0;
        PRDATA  = 8'hEE;
        PSLVERR = 1'b0;
        wcnt++;
      end
    end else begin
      PREADY  = 1'b0;
      PRDATA  = '0;
      PSLVERR = 1'b0;
      wcnt    = 0;
    end
  end

  // Monitor: completed APB transfers.
  always @(negedge HCLK) begin
    apb_exp_t ae;
    if (HRESETn && PSEL && PENABLE && PREADY) begin
      if (apb_q.size() == 0) begin
        check("apb_unexpected", 32'({PADDR, PWRITE, PWDATA, gnt_o}), 32'hFFFF_FFFF);
      end else begin
        ae = apb_q.pop_front();
        check("apb_xfer", 32'({PADDR, PWRITE, PWDATA, gnt_o}), 32'(ae));
      end
    end
  end

  // Monitor: completion pulses.
  always @(negedge HCLK) begin
    done_exp_t de;
    if (|done_o) begin
      if (done_q.size() == 0) begin
        check("done_unexpected", 32'({done_o, rdata_o, err_o}), 32'hFFFF_FFFF);
      end else begin
        de = done_q.pop_front();
        check("done", 32'({done_o, rdata_o, err_o}), 32'(de));
      end
    end
  end

  task automatic push(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                      input logic [R-1:0] g, input logic [DW-1:0] rd, input logic e);
    apb_q.push_back('{addr: a, wr: w, wdata: wd, gnt: g});
    done_q.push_back('{done: g, rdata: rd, err: e});
  endtask

  // Holds rq until ndone completions are seen, then drops it before the next arbitration edge.
  task automatic xfer(input logic [R-1:0] rq, input int ndone, output int pen_cycles);
    int got;
    got = 0;
    pen_cycles = 0;
    @(negedge HCLK);
    req_i = rq;
    for (int c = 0; c < 400 && got < ndone; c++) begin
      @(negedge HCLK);
      if (PENABLE) pen_cycles++;
      if (|done_o) got++;
    end
    req_i = '0;
    check("xfer_done_count", 32'(got), 32'(ndone));
  endtask

  int pen;
  int found;
  int hold;

  initial begin
    // Reset state.
    HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    check("rst_psel_penable_pwrite", 32'({PSEL, PENABLE, PWRITE}), 32'(0));
    check("rst_paddr_pwdata", 32'({PADDR, PWDATA}), 32'(0));
    check("rst_gnt_done", 32'({gnt_o, done_o}), 32'(0));
    check("rst_rdata_err", 32'({rdata_o, err_o}), 32'(0));
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Single write from requester 0, zero wait states, cycle-exact timing.
    we_i = 2'b01; addr_i = {10'h000, 10'h004}; wdata_i = {8'h00, 8'hA5};
    slv_wait = 0; slv_rdata = 8'hC3; slv_err = 1'b0;
    push(10'h004, 1'b1, 8'hA5, 2'b01, 8'h00, 1'b0);
    @(negedge HCLK);
    req_i = 2'b01;
    @(posedge HCLK); #1;
    check("wr_setup_psel_penable_gnt", 32'({PSEL, PENABLE, gnt_o}), 32'({1'b1, 1'b0, 2'b01}));
    @(posedge HCLK); #1;
    check("wr_access_psel_penable", 32'({PSEL, PENABLE}), 32'(2'b11));
    @(posedge HCLK); #1;
    check("wr_end_psel_gnt_done", 32'({PSEL, gnt_o, done_o}), 32'({1'b0, 2'b00, 2'b01}));
    @(negedge HCLK);
    req_i = '0;
    @(negedge HCLK);
    check("wr_done_single_cycle", 32'(done_o), 32'(0));

    // Read from requester 1 with three wait states.
    we_i = 2'b00; addr_i = {10'h000, 10'h004}; wdata_i = {8'h00, 8'hA5};
    slv_wait = 3; slv_rdata = 8'h5A;
    push(10'h000, 1'b0, 8'h00, 2'b10, 8'h5A, 1'b0);
    xfer(2'b10, 1, pen);
    check("rd_wait_access_cycles", 32'(pen), 32'(4));
    check("rd_rdata_held", 32'(rdata_o), 32'(8'h5A));

    // Fairness: both requesters held for six transfers.
    we_i = 2'b01; addr_i = {10'h020, 10'h010}; wdata_i = {8'h00, 8'h11};
    slv_wait = 0; slv_rdata = 8'h33;
    for (int i = 0; i < 3; i++) begin
      push(10'h010, 1'b1, 8'h11, 2'b01, 8'h00, 1'b0);
      push(10'h020, 1'b0, 8'h00, 2'b10, 8'h33, 1'b0);
    end
    xfer(2'b11, 6, pen);
    check("fair_access_cycles", 32'(pen), 32'(6));

    // Slave error, then a clean transfer clears err_o.
    we_i = 2'b00; addr_i = {10'h000, 10'h008}; wdata_i = '0;
    slv_err = 1'b1; slv_rdata = 8'h77;
    push(10'h008, 1'b0, 8'h00, 2'b01, 8'h77, 1'b1);
    xfer(2'b01, 1, pen);
    check("err_held_after_done", 32'(err_o), 32'(1));
    slv_err = 1'b0; slv_rdata = 8'h12;
    push(10'h008, 1'b0, 8'h00, 2'b01, 8'h12, 1'b0);
    xfer(2'b01, 1, pen);

    // Reset during a stalled ACCESS: no completion, requester 0 wins afterwards.
    slv_wait = 1000000;
    @(negedge HCLK);
    req_i = 2'b10;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(negedge HCLK);
      if (PENABLE) found = 1;
    end
    check("rst_mid_reached_access", 32'(found), 32'(1));
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    check("rst_mid_psel_penable", 32'({PSEL, PENABLE}), 32'(0));
    check("rst_mid_gnt_done", 32'({gnt_o, done_o}), 32'(0));
    @(negedge HCLK);
    req_i = '0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    slv_wait = 0; slv_rdata = 8'hAB;
    we_i = 2'b00; addr_i = {10'h3FF, 10'h155}; wdata_i = '0;
    push(10'h155, 1'b0, 8'h00, 2'b01, 8'hAB, 1'b0);
    push(10'h3FF, 1'b0, 8'h00, 2'b10, 8'hAB, 1'b0);
    xfer(2'b11, 2, pen);

    // Stalled slave: watchdog completion, or an indefinite wait when not built.
    slv_wait = 1000000; slv_rdata = 8'h99;
    we_i = 2'b00; addr_i = {10'h000, 10'h0AA}; wdata_i = '0;
`ifdef UART_ARB_TIMEOUT_EN
    done_q.push_back('{done: 2'b01, rdata: 8'h00, err: 1'b1});
    xfer(2'b01, 1, pen);
    check("timeout_access_cycles", 32'(pen), 32'(TO));
`else
    @(negedge HCLK);
    req_i = 2'b01;
    repeat (3) @(negedge HCLK);
    hold = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge HCLK);
      if (PSEL && PENABLE && gnt_o == 2'b01) hold++;
    end
    check("no_timeout_psel_held", 32'(hold), 32'(1000));
    HRESETn = 1'b0;
    @(negedge HCLK);
    req_i = '0;
    @(negedge HCLK);
    HRESETn = 1'b1;
`endif
    slv_wait = 0;

    repeat (5) @(negedge HCLK);
    check("apb_queue_drained", 32'(apb_q.size()), 32'(0));
    check("done_queue_drained", 32'(done_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
